irq_pend_ctrl: RTL and testbench
================================

# irq_pend_ctrl

Eight-source interrupt pending controller that feeds the 8-to-3 priority encoder stage. It captures rising edges (or levels) on eight request lines into a pending register and applies a mask. It presents the highest-priority pending source, as a 3-bit index, through a valid/ack handshake, and clears each source once it is serviced. Bit 7 has the highest priority and bit 0 the lowest, the same ordering as the downstream encoder.

## Interface
- EDGE, 1, 1 = rising-edge capture, 0 = level capture (pending bit set every cycle the request is high)
- CNT_W, 8, width of the lost-request counter

- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset, released synchronously by the integrator
- req  in  8  request lines, synchronous to clk
- mask  in  8  1 = source enabled; masked sources still latch pending, they just cannot be granted
- irq_ack  in  1  consumer accepts the presented index; only meaningful while irq_valid=1
- irq_valid  out  1  an index is being presented
- irq_id  out  3  index of the presented source, 7 = highest priority
- pend  out  8  raw pending register
- lost_cnt  out  CNT_W  saturating count of cycles in which at least one request was dropped

## Operation
- Reset values:
  - irq_valid=0, irq_id=3'b000, pend=8'h00, lost_cnt=0, FSM=IDLE.
  - Internal req_q=8'h00, so a request already high when reset releases counts as an edge.
- Capture:
  - set[i] = req[i] & ~req_q[i] when EDGE=1; set[i] = req[i] when EDGE=0.
  - req_q <= req every cycle.
- Pending update, every cycle: pend <= (pend & ~clr) | set.
  - clr is one-hot at irq_id when irq_valid & irq_ack, otherwise 0.
  - Set wins over clear on the same bit in the same cycle, so the bit stays pending.
- Lost count:
  - lost_cnt increments by 1 in any cycle where set & pend & ~clr is nonzero.
  - It saturates at all-ones, and it counts once per cycle regardless of how many bits were dropped.
- Selection: eligible = pend & mask; the encoded index is the highest set bit of eligible.
- FSM has two states:
  - IDLE: if eligible != 0, latch irq_id <= encoded index, irq_valid <= 1, go to PRESENT. Otherwise stay.
  - PRESENT: irq_id and irq_valid are held stable; a request is never retracted, even if a higher-priority source arrives or the presented source becomes masked. On irq_ack, clear pend[irq_id], set irq_valid <= 0, go to IDLE.
- irq_ack while IDLE is ignored and has no effect on pend.
- irq_id holds its last value while irq_valid=0.

## Timing
- Edge mode, request to pending: req sampled high at edge k (with req_q=0) sets pend at edge k.
- Pending to presentation: IDLE sees eligible during cycle k+1, and irq_valid is 1 after edge k+1. Request-to-valid latency is 2 clocks.
- Ack to release: ack sampled at edge m clears the pend bit and drops irq_valid at edge m.
- Earliest next presentation is after edge m+1, so irq_valid is low for at least one full cycle between grants.
- Back-to-back throughput is one grant per 2 cycles when the consumer acks immediately.
- All outputs are registered; there is no combinational path from req, mask or irq_ack to any output.
- Asserting rst_n low mid-handshake immediately clears all state; a presented index is abandoned and not re-presented.

## Structure
- Shared package/include holds:
  - NUM_SRC=8, ID_W=3
  - state encodings IDLE=1'b0, PRESENT=1'b1
- Sub-module: prio_enc8, a combinational 8-to-3 highest-set-bit encoder with an any_valid output.
  - It uses the same priority ordering as the downstream encoder stage.
  - Outputs 3'b000 when its input is zero.
  - It is instantiated once on eligible.
- The rest is flat: capture and pending registers, FSM, and the counter.

## Test plan
- Reset, then pulse req=8'h04 for one cycle with mask=8'hFF → pend=8'h04; irq_valid=1 and irq_id=2 two clocks after the req sample. Ack → pend=8'h00 and irq_valid=0 on the same edge.
- req=8'h81 in the same cycle, acking each grant the cycle it appears → grants irq_id=7, then irq_id=0, with exactly one idle cycle between them.
- Present irq_id=3, then raise req bit 6 before ack → irq_id stays 3 until ack; the next grant is 6.
- mask=8'h0F with req=8'hF0 → pend=8'hF0 and irq_valid stays 0. Then mask=8'hFF → irq_id=7 one clock later.
- While pend[5]=1, re-pulse req[5] → lost_cnt goes 0→1. Re-pulse req[5] in the same cycle as the ack of id 5 → pend[5] remains 1 and lost_cnt is unchanged. With CNT_W=2, force 5 losses → lost_cnt=3.
- Assert rst_n low while irq_valid=1 → irq_valid=0, pend=8'h00, lost_cnt=0 asynchronously. After release with req held at 8'h02 → one new grant of irq_id=1.

Source files
------------

// File: rtl/irq_pend_ctrl_pkg.sv
// Shared sizes and FSM encoding for the interrupt pending controller.
// No logic, so there is no latency.
// No flow control, so there is no backpressure.
package irq_pend_ctrl_pkg;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  typedef logic [NUM_SRC-1:0] src_vec_t;
  typedef logic [ID_W-1:0]    src_id_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/irq_pend_ctrl_prio_enc8.sv
// Highest-set-bit encoder; bit 7 wins, as in the downstream encoder stage.
// Latency: combinational.
// Backpressure: none; the output follows the input, and it is 0 when no bit is set.
module prio_enc8
  import irq_pend_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] in_vec,
  output logic [ID_W-1:0]    id,
  output logic               any_valid
);

  // Scan upward so that the last set bit found, which is the highest, decides the result
  always_comb begin
    id        = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (in_vec[i]) begin
        id        = ID_W'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pend_ctrl.sv
// Captures eight interrupt requests as pending and grants the highest eligible one by valid/ack.
// Latency: 2 clocks from request to irq_valid, and the pend bit clears on the ack edge.
// Backpressure: an index stays presented until acked; new requests keep accumulating in pend.
module irq_pend_ctrl
  import irq_pend_ctrl_pkg::*;
#(
  parameter bit EDGE  = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  req,
  input  logic [NUM_SRC-1:0]  mask,
  input  logic                irq_ack,
  output logic                irq_valid,
  output logic [ID_W-1:0]     irq_id,
  output logic [NUM_SRC-1:0]  pend,
  output logic [CNT_W-1:0]    lost_cnt
);

  state_t     state;
  src_vec_t   req_q;
  src_vec_t   set_vec;
  src_vec_t   clr_vec;
  src_vec_t   eligible;
  src_id_t    enc_id;
  logic       enc_any;
  logic       grant_done;
  logic       lost_hit;

  assign grant_done = (state == PRESENT) && irq_ack;
  assign eligible   = pend & mask;
  assign lost_hit   = |(set_vec & pend & ~clr_vec);

  // Build the new-request vector from edges or levels, and the one-hot clear for the acked source
  always_comb begin
    set_vec = EDGE ? (req & ~req_q) : req;
    clr_vec = '0;
    if (grant_done) begin
      clr_vec[irq_id] = 1'b1;
    end
  end

  prio_enc8 u_prio_enc8 (
    .in_vec    (eligible),
    .id        (enc_id),
    .any_valid (enc_any)
  );

  // Request history for edge detection. It resets to 0 so that a line already high counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req;
    end
  end

  // Pending register. The set term comes after the clear, so a re-request on the acked bit keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_vec) | set_vec;
    end
  end

  // Count cycles that dropped a request onto an already-pending bit, saturating at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_cnt <= '0;
    end else if (lost_hit && (lost_cnt != {CNT_W{1'b1}})) begin
      lost_cnt <= lost_cnt + CNT_W'(1);
    end
  end

  // Grant FSM. A presented index is held until acked and is never retracted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_any) begin
            irq_id    <= enc_id;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Directed bench for irq_pend_ctrl (edge mode, 2-bit lost counter).
// Latency: not applicable.
// Backpressure: the bench acts as the consumer and chooses when to ack.
module tb_irq_pend_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pend;
  logic [1:0] lost_cnt;

  int checks = 0;
  int errors = 0;

  irq_pend_ctrl #(.EDGE(1'b1), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pend      (pend),
    .lost_cnt  (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then move 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 8'h00;
    mask    = 8'hFF;
    irq_ack = 1'b0;
    #2;
    chk("rst_valid", 32'(irq_valid), 32'h0);
    chk("rst_id",    32'(irq_id),    32'h0);
    chk("rst_pend",  32'(pend),      32'h0);
    chk("rst_lost",  32'(lost_cnt),  32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Single request on bit 2
    req = 8'h04;
    step();
    chk("t1_pend",   32'(pend),      32'h04);
    chk("t1_nvalid", 32'(irq_valid), 32'h0);
    req = 8'h00;
    step();
    chk("t1_valid",  32'(irq_valid), 32'h1);
    chk("t1_id",     32'(irq_id),    32'h2);
    irq_ack = 1'b1;
    step();
    chk("t1_ack_pend",  32'(pend),      32'h00);
    chk("t1_ack_valid", 32'(irq_valid), 32'h0);
    irq_ack = 1'b0;
    step();
    chk("t1_idle_ack_ignored", 32'(irq_valid), 32'h0);

    // Two simultaneous requests, with each grant acked immediately
    req = 8'h81;
    step();
    chk("t2_pend", 32'(pend), 32'h81);
    req = 8'h00;
    step();
    chk("t2_valid7", 32'(irq_valid), 32'h1);
    chk("t2_id7",    32'(irq_id),    32'h7);
    irq_ack = 1'b1;
    step();
    chk("t2_gap_valid", 32'(irq_valid), 32'h0);
    chk("t2_gap_pend",  32'(pend),      32'h01);
    irq_ack = 1'b0;
    step();
    chk("t2_valid0", 32'(irq_valid), 32'h1);
    chk("t2_id0",    32'(irq_id),    32'h0);
    irq_ack = 1'b1;
    step();
    chk("t2_done_pend",  32'(pend),      32'h00);
    chk("t2_done_valid", 32'(irq_valid), 32'h0);
    irq_ack = 1'b0;

    // A higher-priority arrival must not retract the presented index
    req = 8'h08;
    step();
    req = 8'h00;
    step();
    chk("t3_id3", 32'(irq_id), 32'h3);
    req = 8'h40;
    step();
    chk("t3_pend48", 32'(pend),   32'h48);
    chk("t3_hold3a", 32'(irq_id), 32'h3);
    req = 8'h00;
    step();
    chk("t3_hold3b", 32'(irq_id),    32'h3);
    chk("t3_holdv",  32'(irq_valid), 32'h1);
    irq_ack = 1'b1;
    step();
    chk("t3_ack_pend", 32'(pend), 32'h40);
    irq_ack = 1'b0;
    step();
    chk("t3_valid6", 32'(irq_valid), 32'h1);
    chk("t3_id6",    32'(irq_id),    32'h6);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("t3_done_pend", 32'(pend), 32'h00);

    // Masked sources still latch as pending but are not granted
    mask = 8'h0F;
    req  = 8'hF0;
    step();
    chk("t4_pend", 32'(pend), 32'hF0);
    req = 8'h00;
    step();
    step();
    chk("t4_masked_nvalid", 32'(irq_valid), 32'h0);
    mask = 8'hFF;
    step();
    chk("t4_unmask_valid", 32'(irq_valid), 32'h1);
    chk("t4_unmask_id",    32'(irq_id),    32'h7);
    for (int j = 6; j >= 4; j--) begin
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      step();
      chk("t4_drain_id", 32'(irq_id), 32'(j));
    end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("t4_drain_pend", 32'(pend), 32'h00);

    // Lost-request counting
    req = 8'h20;
    step();
    req = 8'h00;
    step();
    chk("t5_id5",  32'(irq_id),   32'h5);
    chk("t5_lost0", 32'(lost_cnt), 32'h0);
    req = 8'h20;
    step();
    chk("t5_lost1", 32'(lost_cnt), 32'h1);
    chk("t5_pend",  32'(pend),     32'h20);
    req = 8'h00;
    step();
    req     = 8'h20;
    irq_ack = 1'b1;
    step();
    chk("t5_setwins_pend",  32'(pend),      32'h20);
    chk("t5_setwins_lost",  32'(lost_cnt),  32'h1);
    chk("t5_setwins_valid", 32'(irq_valid), 32'h0);
    req     = 8'h00;
    irq_ack = 1'b0;
    step();
    chk("t5_repres_id", 32'(irq_id),    32'h5);
    chk("t5_repres_v",  32'(irq_valid), 32'h1);
    for (int j = 0; j < 5; j++) begin
      req = 8'h20;
      step();
      req = 8'h00;
      step();
    end
    chk("t5_saturate", 32'(lost_cnt), 32'h3);

    // Asynchronous reset in the middle of a handshake
    req   = 8'h02;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(irq_valid), 32'h0);
    chk("t6_async_pend",  32'(pend),      32'h00);
    chk("t6_async_lost",  32'(lost_cnt),  32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_pend02", 32'(pend), 32'h02);
    step();
    chk("t6_valid", 32'(irq_valid), 32'h1);
    chk("t6_id1",   32'(irq_id),    32'h1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    chk("t6_ack_pend", 32'(pend), 32'h00);
    step();
    step();
    chk("t6_single_grant", 32'(irq_valid), 32'h0);
    req = 8'h00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
